// File: rtl/fpu_alt_feed.sv
// Alternate-operand feeder: queues 68-bit operand pairs and presents the head entry
// on the ALT port for one cycle per alt_req. Option macro: FPU_ALT_FEED_BYPASS_EN.
module fpu_alt_feed #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_en,
  input  logic [1:0]               push_mask,
  input  logic [67:0]              push_data0,
  input  logic [67:0]              push_data1,
  output logic                     push_full,
  input  logic                     alt_req,
  input  logic                     flush,
  output logic [1:0]               ALT_INP,
  output logic [67:0]              ALTDATA0,
  output logic [67:0]              ALTDATA1,
  output logic                     alt_miss,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [1:0]  mask;
    logic [67:0] d1;
    logic [67:0] d0;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic            full_reg;
  logic            overflow_reg;
  logic            miss_reg;
  logic [1:0]      inp_reg;
  logic [67:0]     data0_reg;
  logic [67:0]     data1_reg;

  logic            empty;
  logic            push_ok;
  logic            pop;
  logic            bypass;
  logic            miss;
  logic            wr;
  entry_t          push_entry;

  always_comb begin
    empty      = (count_reg == '0);
    push_ok    = push_en && !full_reg && !flush;
    pop        = alt_req && !empty && !flush;
`ifdef FPU_ALT_FEED_BYPASS_EN
    // An empty queue hands a same-cycle push straight to the output stage.
    bypass     = push_ok && alt_req && empty;
`else
    bypass     = 1'b0;
`endif
    miss       = alt_req && empty && !flush && !bypass;
    wr         = push_ok && !bypass;
    push_entry = '{mask: push_mask, d1: push_data1, d0: push_data0};
    if (flush)
      count_next = '0;
    else
      count_next = count_reg + CW'(wr) - CW'(pop);
  end

  // Storage has no reset so it maps onto plain RAM; validity is tracked by count_reg.
  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr_reg] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      miss_reg     <= 1'b0;
      inp_reg      <= 2'b00;
      data0_reg    <= '0;
      data1_reg    <= '0;
    end else begin
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(DEPTH));
      miss_reg  <= miss;
      if (push_en && full_reg && !flush)
        overflow_reg <= 1'b1;

      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (wr)
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)
          rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end

      // Valid is a single-cycle pulse; data holds its last value otherwise.
      if (flush) begin
        inp_reg <= 2'b00;
      end else if (pop) begin
        inp_reg   <= mem[rd_ptr_reg].mask;
        data0_reg <= mem[rd_ptr_reg].d0;
        data1_reg <= mem[rd_ptr_reg].d1;
      end else if (bypass) begin
        inp_reg   <= push_mask;
        data0_reg <= push_data0;
        data1_reg <= push_data1;
      end else begin
        inp_reg <= 2'b00;
      end
    end
  end

  assign push_full = full_reg;
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign alt_miss  = miss_reg;
  assign ALT_INP   = inp_reg;
  assign ALTDATA0  = data0_reg;
  assign ALTDATA1  = data1_reg;

endmodule

// File: tb/tb_fpu_alt_feed.sv
// Directed bench for fpu_alt_feed: queue-based reference model checked every cycle,
// plus literal expectations taken from the intended behaviour.
module tb_fpu_alt_feed;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_en;
  logic [1:0]  push_mask;
  logic [67:0] push_data0;
  logic [67:0] push_data1;
  logic        push_full;
  logic        alt_req;
  logic        flush;
  logic [1:0]  ALT_INP;
  logic [67:0] ALTDATA0;
  logic [67:0] ALTDATA1;
  logic        alt_miss;
  logic        overflow;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_alt_feed #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push_en(push_en), .push_mask(push_mask),
    .push_data0(push_data0), .push_data1(push_data1), .push_full(push_full),
    .alt_req(alt_req), .flush(flush), .ALT_INP(ALT_INP), .ALTDATA0(ALTDATA0),
    .ALTDATA1(ALTDATA1), .alt_miss(alt_miss), .overflow(overflow), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: queue of {mask, d1, d0}
  logic [137:0] q[$];
  logic [1:0]   exp_inp  = 2'b00;
  logic [67:0]  exp_d0   = '0;
  logic [67:0]  exp_d1   = '0;
  logic         exp_miss = 1'b0;
  logic         exp_ovf  = 1'b0;
  bit           model_live = 1'b0;

  always @(posedge clk) begin
    logic [137:0] e;
    bit was_full;
    bit was_empty;
    if (rst) begin
      q.delete();
      exp_inp = 2'b00; exp_d0 = '0; exp_d1 = '0; exp_miss = 1'b0; exp_ovf = 1'b0;
      model_live = 1'b1;
    end else if (flush) begin
      q.delete();
      exp_inp = 2'b00; exp_miss = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      exp_inp  = 2'b00;
      exp_miss = 1'b0;
      if (push_en && was_full) exp_ovf = 1'b1;
      if (alt_req && !was_empty) begin
        e = q.pop_front();
        exp_inp = e[137:136]; exp_d1 = e[135:68]; exp_d0 = e[67:0];
      end
`ifdef FPU_ALT_FEED_BYPASS_EN
      if (alt_req && was_empty && push_en) begin
        exp_inp = push_mask; exp_d0 = push_data0; exp_d1 = push_data1;
      end else begin
        if (alt_req && was_empty) exp_miss = 1'b1;
        if (push_en && !was_full) q.push_back({push_mask, push_data1, push_data0});
      end
`else
      if (alt_req && was_empty) exp_miss = 1'b1;
      if (push_en && !was_full) q.push_back({push_mask, push_data1, push_data0});
`endif
    end
  end

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      chk("m_alt_inp", 68'(ALT_INP), 68'(exp_inp));
      if (exp_inp[0]) chk("m_altdata0", ALTDATA0, exp_d0);
      if (exp_inp[1]) chk("m_altdata1", ALTDATA1, exp_d1);
      chk("m_alt_miss", 68'(alt_miss), 68'(exp_miss));
      chk("m_count", 68'(count), 68'(q.size()));
      chk("m_push_full", 68'(push_full), 68'(q.size() == DEPTH));
      chk("m_overflow", 68'(overflow), 68'(exp_ovf));
    end
  end

  task automatic drive(input bit pe, input logic [1:0] m, input logic [67:0] d0,
                       input logic [67:0] d1, input bit req, input bit fl);
    push_en = pe; push_mask = m; push_data0 = d0; push_data1 = d1;
    alt_req = req; flush = fl;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 2'b00, '0, '0, 0, 0);
  endtask

  task automatic push(input logic [1:0] m, input logic [67:0] d0, input logic [67:0] d1);
    drive(1, m, d0, d1, 0, 0);
  endtask

  task automatic pop();
    drive(0, 2'b00, '0, '0, 1, 0);
  endtask

  initial begin
    rst = 1'b1;
    push_en = 0; push_mask = 0; push_data0 = '0; push_data1 = '0; alt_req = 0; flush = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_count", 68'(count), 68'd0);
    chk("rst_alt_inp", 68'(ALT_INP), 68'd0);
    chk("rst_full", 68'(push_full), 68'd0);
    chk("rst_ovf", 68'(overflow), 68'd0);
    rst = 1'b0;

    // Single push, idle, pop
    push(2'b11, 68'h1, 68'h2);
    idle();
    pop();
    chk("t1_inp", 68'(ALT_INP), 68'h3);
    chk("t1_d0", ALTDATA0, 68'h1);
    chk("t1_d1", ALTDATA1, 68'h2);
    idle();
    chk("t1_inp_after", 68'(ALT_INP), 68'h0);
    chk("t1_count", 68'(count), 68'd0);
    $display("txn single push/pop done count=%0d", count);

    // Fill, overflow, drain in order
    for (int i = 1; i <= 5; i++) push(2'b11, 68'(i), 68'(100 + i));
    chk("t2_full", 68'(push_full), 68'd1);
    chk("t2_ovf", 68'(overflow), 68'd1);
    chk("t2_count", 68'(count), 68'd4);
    for (int i = 1; i <= 4; i++) begin
      pop();
      chk("t2_pop_d0", ALTDATA0, 68'(i));
      $display("txn drain pop d0=%0h d1=%0h", ALTDATA0, ALTDATA1);
    end
    idle();
    chk("t2_count_end", 68'(count), 68'd0);

    // Steady-state push+pop with pointer wrap
    push(2'b01, 68'h20, 68'h0);
    push(2'b10, 68'h0, 68'h21);
    for (int i = 0; i < 6; i++) begin
      drive(1, 2'b11, 68'(16'h30 + i), 68'(16'h40 + i), 1, 0);
      chk("t3_count", 68'(count), 68'd2);
      $display("txn stream i=%0d inp=%b d0=%0h d1=%0h", i, ALT_INP, ALTDATA0, ALTDATA1);
    end
    chk("t3_last_d0", ALTDATA0, 68'h33);
    pop();
    pop();
    chk("t3_tail_d0", ALTDATA0, 68'h35);
    idle();

    // Empty-queue request
    pop();
    chk("t4_miss", 68'(alt_miss), 68'd1);
    chk("t4_inp", 68'(ALT_INP), 68'd0);
    idle();
    chk("t4_miss_clr", 68'(alt_miss), 68'd0);
    drive(1, 2'b01, 68'hA, 68'h0, 1, 0);
`ifdef FPU_ALT_FEED_BYPASS_EN
    chk("t4_byp_inp", 68'(ALT_INP), 68'h1);
    chk("t4_byp_d0", ALTDATA0, 68'hA);
    chk("t4_byp_count", 68'(count), 68'd0);
`else
    chk("t4_nb_miss", 68'(alt_miss), 68'd1);
    chk("t4_nb_count", 68'(count), 68'd1);
    pop();
    chk("t4_nb_d0", ALTDATA0, 68'hA);
`endif
    $display("txn empty request done count=%0d", count);
    idle();

    // Flush overrides push and pop
    for (int i = 0; i < 3; i++) push(2'b11, 68'(16'h50 + i), 68'(16'h60 + i));
    drive(1, 2'b11, 68'h77, 68'h78, 1, 1);
    chk("t5_count", 68'(count), 68'd0);
    chk("t5_inp", 68'(ALT_INP), 68'd0);
    chk("t5_miss", 68'(alt_miss), 68'd0);
    pop();
    chk("t5_post_miss", 68'(alt_miss), 68'd1);
    $display("txn flush done count=%0d", count);
    idle();

    // Reset with entries queued and a pop in flight
    push(2'b11, 68'h90, 68'h91);
    push(2'b11, 68'h92, 68'h93);
    pop();
    chk("t6_inflight", 68'(ALT_INP), 68'h3);
    rst = 1'b1;
    idle();
    chk("t6_inp", 68'(ALT_INP), 68'd0);
    chk("t6_count", 68'(count), 68'd0);
    chk("t6_ovf", 68'(overflow), 68'd0);
    chk("t6_d0", ALTDATA0, 68'd0);
    rst = 1'b0;
    pop();
    chk("t6_miss", 68'(alt_miss), 68'd1);
    $display("txn reset mid-op done miss=%0d", alt_miss);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_alt_feed.md
# fpu_alt_feed

Transmit-side feeder for the FP store/SIMD lane alternate-operand port (`ALT_INP`, `ALTDATA0`, `ALTDATA1`). The integer/load side pushes 68-bit operand pairs into a small FIFO. When the FP issue stage raises `alt_req`, the feeder pops the head entry and drives it onto the alternate-operand port for exactly one cycle. This block sits between the integer-to-FP move path and the third FP store lane, which is the only lane with the ALT port wired.

## Interface
- `DEPTH`, default 4: FIFO entries; must be a power of two, ≥2.
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high.
- `push_en` in 1: write one entry this cycle.
- `push_mask` in 2: per-slot valid of the pushed entry (bit0 = `ALTDATA0`, bit1 = `ALTDATA1`).
- `push_data0` in 68: slot-0 operand.
- `push_data1` in 68: slot-1 operand.
- `push_full` out 1: FIFO holds `DEPTH` entries (registered).
- `alt_req` in 1: FP issue consumes the head entry this cycle.
- `flush` in 1: discard all queued entries.
- `ALT_INP` out 2: per-slot valid presented to the FP lane.
- `ALTDATA0` out 68: slot-0 data.
- `ALTDATA1` out 68: slot-1 data.
- `alt_miss` out 1: one-cycle pulse; `alt_req` found nothing to pop.
- `overflow` out 1: sticky; a push was dropped while full. Cleared only by `rst`.
- `count` out $clog2(DEPTH)+1: current occupancy (registered).

## Operation
- FIFO storage: `DEPTH` × (2 + 68 + 68) bits.
- Read/write pointers are $clog2(DEPTH) bits and wrap modulo `DEPTH`.
- `count` is the authoritative occupancy.
- Push: accepted iff `push_en` && !`push_full` && !`flush`. The entry is written at the write pointer, which then increments.
- Push while full: the entry is dropped, the pointer and `count` do not change, and `overflow` is set.
- Pop: occurs iff `alt_req` && `count`≠0 && !`flush`. The head entry is loaded into the output registers and the read pointer increments.
- Simultaneous push and pop: both happen and `count` is unchanged. When full, the push is still refused, because `push_full` reflects the start-of-cycle state.
- Empty-queue request:
  - `alt_req` with `count`==0 raises `alt_miss` the next cycle.
  - `ALT_INP` stays 0 that cycle.
  - A same-cycle push is not bypassed; the bypass option is described under Configuration.
- Output registers hold data for one cycle only:
  - With no pop, `ALT_INP` returns to 2'b00 the following cycle.
  - `ALTDATA0`/`ALTDATA1` hold their last value; they are don't-care when the matching `ALT_INP` bit is 0.
- Flush:
  - Both pointers and `count` go to 0.
  - `ALT_INP` is driven 0 the next cycle.
  - Flush overrides push, pop and `alt_miss`.
  - `overflow` is unchanged.
- Reset: all outputs are 0 (`push_full`=0, `ALT_INP`=0, `ALTDATA0/1`=0, `alt_miss`=0, `overflow`=0, `count`=0), and both pointers are 0.
- Reset mid-operation: queued entries are lost and no further output valid appears.

## Timing
- Pop latency: `alt_req` sampled at edge N produces `ALT_INP`/`ALTDATA*` valid during cycle N+1, for exactly one cycle. This matches the FP lane's registered operand stage.
- `alt_miss` asserts in cycle N+1 for a miss at N.
- `push_full` and `count` update at the edge following a push, pop or flush.
- Push-to-visible latency: an entry pushed at edge N can be popped by `alt_req` at N+1, giving output at N+2.
- Back-to-back `alt_req` every cycle drains one entry per cycle, with no bubbles while `count`>0.

## Configuration
- Macro: `FPU_ALT_FEED_BYPASS_EN`.
- Defined: when `count`==0 and `alt_req`, an accepted push in the same cycle bypasses the FIFO and is driven to the outputs at N+1.
  - No `alt_miss` is raised.
  - The entry is not stored, so the pointers and `count` are unchanged.
  - `flush` still kills the bypass.
- Undefined: no bypass. That case produces `alt_miss`, and the pushed entry is enqueued normally.

## Test plan
- Reset, then push {mask 2'b11, d0=68'h1, d1=68'h2}, then idle one cycle, then `alt_req` -> next cycle `ALT_INP`=2'b11, `ALTDATA0`=68'h1, `ALTDATA1`=68'h2; the cycle after that, `ALT_INP`=0 and `count`=0.
- Push 4 entries (DEPTH=4), then a 5th -> `push_full`=1, the 5th is dropped, `overflow`=1. The next 4 pops return entries 1–4 in order and `count` reaches 0.
- With the FIFO at 2 entries, push and `alt_req` in the same cycle for 6 cycles -> `count` stays 2, outputs follow FIFO order, and the pointers wrap correctly.
- `alt_req` on an empty FIFO with no push -> `alt_miss`=1 for one cycle, `ALT_INP`=0.
  - With a same-cycle push {mask 2'b01, d0=68'hA}: with `FPU_ALT_FEED_BYPASS_EN` -> `ALT_INP`=2'b01, `ALTDATA0`=68'hA, `count`=0. Without the macro -> `alt_miss`=1, `count`=1.
- Three entries queued, `flush` asserted together with push and `alt_req` -> `count`=0, `ALT_INP`=0, `alt_miss`=0 the next cycle, and a subsequent `alt_req` misses.
- `rst` asserted with 2 entries queued and a pop in flight -> all outputs 0 at the next edge, and a following `alt_req` gives `alt_miss`.
